writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue_pkg.sv | 12 +
 rtl/wbq_match.sv | 32 +++
 rtl/writeback_queue.sv | 87 ++++++++
 tb/tb_writeback_queue.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/writeback_queue_pkg.sv
// Shared widths, the zero-register index and the entry layout for the writeback queue.
package writeback_queue_pkg;
  localparam int unsigned DATA_W        = 64;
  localparam int unsigned IDX_W         = 5;
  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam logic [IDX_W-1:0] XZR_IDX  = 5'd31;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wbEntry_t;
endpackage

// File: rtl/wbq_match.sv
// Youngest-match search over the live window [head, head+count) of the queue storage.
module wbq_match
  import writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  wbEntry_t [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]     head,
  input  logic [PTR_W:0]       count,
  input  logic [IDX_W-1:0]     key,
  output logic                 hit,
  output logic [DATA_W-1:0]    data
);

  logic [PTR_W-1:0] slot;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if ((PTR_W+1)'(i) < count && key != XZR_IDX && entries[slot].idx == key) begin
        hit  = 1'b1;
        data = entries[slot].data;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Register-file writeback FIFO with youngest-entry forwarding for two decode read ports.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     Clk,
  input  logic                     ResetL,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [IDX_W-1:0]         InRW,
  input  logic [DATA_W-1:0]        InData,
  input  logic                     WbStall,
  output logic                     RegWr,
  output logic [IDX_W-1:0]         RW,
  output logic [DATA_W-1:0]        BusW,
  input  logic [IDX_W-1:0]         RA,
  input  logic [IDX_W-1:0]         RB,
  output logic                     FwdAHit,
  output logic                     FwdBHit,
  output logic [DATA_W-1:0]        FwdA,
  output logic [DATA_W-1:0]        FwdB,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wbEntry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic                 push;
  logic                 pop;
  logic                 notEmpty;

  assign notEmpty = (count != '0);
  assign InReady  = (count < CNT_W'(DEPTH));
  // Zero-register writes are accepted but never stored.
  assign push     = InValid && InReady && (InRW != XZR_IDX);
  assign pop      = notEmpty && !WbStall;

  assign RegWr = pop;
  assign RW    = notEmpty ? entries[head].idx  : '0;
  assign BusW  = notEmpty ? entries[head].data : '0;
  assign Count = count;

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; validity is defined solely by head/count.
  always_ff @(posedge Clk) begin
    if (push) entries[tail] <= '{idx: InRW, data: InData};
  end

  wbq_match #(.DEPTH(DEPTH)) uMatchA (
    .entries(entries),
    .head   (head),
    .count  (count),
    .key    (RA),
    .hit    (FwdAHit),
    .data   (FwdA)
  );

  wbq_match #(.DEPTH(DEPTH)) uMatchB (
    .entries(entries),
    .head   (head),
    .count  (count),
    .key    (RB),
    .hit    (FwdBHit),
    .data   (FwdB)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: directed requests, register-file writes checked by a monitor.
module tb_writeback_queue;

  logic        Clk = 1'b0;
  logic        ResetL;
  logic        InValid;
  logic        InReady;
  logic [4:0]  InRW;
  logic [63:0] InData;
  logic        WbStall;
  logic        RegWr;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic        FwdAHit;
  logic        FwdBHit;
  logic [63:0] FwdA;
  logic [63:0] FwdB;
  logic [2:0]  Count;

  typedef struct {
    logic [4:0]  rw;
    logic [63:0] data;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  writeback_queue #(.DEPTH(4)) dut (
    .Clk(Clk), .ResetL(ResetL), .InValid(InValid), .InReady(InReady),
    .InRW(InRW), .InData(InData), .WbStall(WbStall), .RegWr(RegWr),
    .RW(RW), .BusW(BusW), .RA(RA), .RB(RB), .FwdAHit(FwdAHit),
    .FwdBHit(FwdBHit), .FwdA(FwdA), .FwdB(FwdB), .Count(Count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One request per call; the scoreboard learns of every request expected to be stored.
  task automatic enq(input logic [4:0] rw, input logic [63:0] data);
    InValid = 1'b1;
    InRW    = rw;
    InData  = data;
    if (rw != 5'd31) sbq.push_back('{rw: rw, data: data});
    @(posedge Clk);
    #1 InValid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Monitor: every register-file write must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge Clk);
      if (RegWr === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_write", 64'(RW), 64'd0);
          check("unexpected_write_regwr", 64'(RegWr), 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("wr_RW", 64'(RW), 64'(e.rw));
          check("wr_BusW", BusW, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ResetL = 1'b0; InValid = 1'b0; InRW = '0; InData = '0;
    WbStall = 1'b0; RA = '0; RB = '0;
    #12;
    check("rst_Count", 64'(Count), 64'd0);
    check("rst_InReady", 64'(InReady), 64'd1);
    check("rst_RegWr", 64'(RegWr), 64'd0);
    check("rst_RW", 64'(RW), 64'd0);
    check("rst_BusW", BusW, 64'd0);
    check("rst_FwdAHit", 64'(FwdAHit), 64'd0);
    check("rst_FwdBHit", 64'(FwdBHit), 64'd0);
    ResetL = 1'b1;
    @(posedge Clk); #1;

    // Single request flows straight through.
    enq(5'd3, 64'hAA);
    check("t1_Count", 64'(Count), 64'd1);
    check("t1_RegWr", 64'(RegWr), 64'd1);
    check("t1_RW", 64'(RW), 64'd3);
    check("t1_BusW", BusW, 64'hAA);
    cycles(1);
    check("t1_Count_after", 64'(Count), 64'd0);
    check("t1_RegWr_after", 64'(RegWr), 64'd0);

    // Fill under stall, attempt overflow, then drain in order.
    WbStall = 1'b1;
    for (int i = 1; i <= 4; i++) enq(5'(i), 64'h100 + 64'(i));
    check("t2_Count_full", 64'(Count), 64'd4);
    check("t2_InReady_full", 64'(InReady), 64'd0);
    check("t2_RegWr_stall", 64'(RegWr), 64'd0);
    RA = 5'd2; RB = 5'd4; #1;
    check("t2_FwdA", FwdA, 64'h102);
    check("t2_FwdB", FwdB, 64'h104);
    InValid = 1'b1; InRW = 5'd9; InData = 64'hDEAD;
    @(posedge Clk); #1;
    InValid = 1'b0;
    check("t2_Count_no_overwrite", 64'(Count), 64'd4);
    WbStall = 1'b0; #1;
    check("t2_RegWr_release", 64'(RegWr), 64'd1);
    check("t2_head_RW", 64'(RW), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      check("t2_Count_drain", 64'(Count), 64'(3 - i));
    end
    check("t2_InReady_empty", 64'(InReady), 64'd1);

    // Zero-register request is swallowed.
    enq(5'd31, 64'hFF);
    check("t3_Count", 64'(Count), 64'd0);
    check("t3_RegWr", 64'(RegWr), 64'd0);
    cycles(2);

    // Forwarding: youngest wins, index 31 ignored, same-cycle request ignored.
    WbStall = 1'b1;
    enq(5'd5, 64'h10);
    enq(5'd5, 64'h20);
    RA = 5'd5; RB = 5'd31; #1;
    check("t4_FwdAHit", 64'(FwdAHit), 64'd1);
    check("t4_FwdA", FwdA, 64'h20);
    check("t4_FwdBHit_xzr", 64'(FwdBHit), 64'd0);
    check("t4_FwdB_xzr", FwdB, 64'd0);
    RB = 5'd6; InValid = 1'b1; InRW = 5'd6; InData = 64'h30;
    sbq.push_back('{rw: 5'd6, data: 64'h30});
    #1;
    check("t4_FwdBHit_inflight", 64'(FwdBHit), 64'd0);
    @(posedge Clk); #1;
    InValid = 1'b0;
    check("t4_FwdBHit_stored", 64'(FwdBHit), 64'd1);
    check("t4_FwdB_stored", FwdB, 64'h30);
    WbStall = 1'b0; #1;
    check("t4_RegWr_head", 64'(RegWr), 64'd1);
    check("t4_FwdA_during_write", FwdA, 64'h20);
    cycles(3);
    check("t4_Count_drained", 64'(Count), 64'd0);

    // Reset with two entries pending: nothing may be written afterwards.
    WbStall = 1'b1;
    enq(5'd8, 64'h80);
    enq(5'd9, 64'h90);
    check("t5_Count_pre", 64'(Count), 64'd2);
    RA = 5'd8;
    ResetL = 1'b0; #1;
    check("t5_Count_rst", 64'(Count), 64'd0);
    check("t5_RegWr_rst", 64'(RegWr), 64'd0);
    check("t5_FwdAHit_rst", 64'(FwdAHit), 64'd0);
    check("t5_InReady_rst", 64'(InReady), 64'd1);
    sbq.delete();
    #4 ResetL = 1'b1;
    WbStall = 1'b0;
    cycles(3);
    check("t5_Count_post", 64'(Count), 64'd0);

    // Steady streaming: one in, one out each cycle at Count 3.
    WbStall = 1'b1;
    for (int i = 0; i < 3; i++) enq(5'(10 + i), 64'h200 + 64'(i));
    WbStall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enq(5'(20 + i), 64'h300 + 64'(i));
      check("t6_Count", 64'(Count), 64'd3);
      check("t6_InReady", 64'(InReady), 64'd1);
    end
    cycles(3);
    check("t6_Count_drained", 64'(Count), 64'd0);
    cycles(1);
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
